lif_neuron_multi: RTL and testbench

Parametrised successor to the single-synapse LIF neuron top. It has N weighted synapse inputs, a programmable threshold, a shift-based exponential leak and a programmable refractory period. All configuration arrives over the existing serial set_vars interface as one bit-serial frame. The block drops in wherever a single neuron is used today, with V and axon keeping their meaning.

---
 rtl/lif_neuron_multi.sv | 151 +++++++++++++++
 tb/tb_lif_neuron_multi.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_multi.sv
//==============================================================================
// Module      : lif_neuron_multi
// Description : N-synapse leaky integrate-and-fire neuron with bit-serial
//               configuration of weights, threshold, leak shift and refractory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lif_neuron_multi #(
  parameter int W      = 8,
  parameter int N      = 4,
  parameter int WW     = 4,
  parameter int LEAK_W = 3,
  parameter int REF_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_vars,
  input  logic         cfg_bit,
  input  logic [N-1:0] syn,
  output logic         axon,
  output logic [W-1:0] V,
  output logic         cfg_err
);

  localparam int c_frame_len = N*WW + W + LEAK_W + REF_W;
  localparam int c_cnt_w     = $clog2(c_frame_len + 2);
  localparam int c_sum_w     = W + $clog2(N);
  localparam int c_nv_w      = c_sum_w + 1;
  localparam int c_thr_lsb   = LEAK_W + REF_W;
  localparam int c_w_lsb     = c_thr_lsb + W;

  typedef enum logic [0:0] {
    ST_INTEG = 1'b0,
    ST_REFR  = 1'b1
  } state_t;

  logic [c_frame_len-1:0] r_sreg;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [N-1:0][WW-1:0]   r_w;
  logic [W-1:0]           r_thresh;
  logic [LEAK_W-1:0]      r_leak_sh;
  logic [REF_W-1:0]       r_refr;
  logic [REF_W-1:0]       r_rcnt;
  state_t                 r_state;

  logic                   w_commit;
  logic                   w_frozen;
  logic [c_sum_w-1:0]     w_sum;
  logic [W-1:0]           w_leak;
  logic [c_nv_w-1:0]      w_nv;
  logic [W-1:0]           w_nv_sat;
  logic                   w_fire;
  state_t                 w_state_nxt;
  logic [W-1:0]           w_v_nxt;
  logic                   w_axon_nxt;
  logic [REF_W-1:0]       w_rcnt_nxt;

  // A nonzero count means at least one config bit arrived since the last commit
  assign w_commit = !set_vars && (r_cnt != '0);
  assign w_frozen = set_vars || w_commit;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      if (syn[i]) w_sum = w_sum + c_sum_w'(r_w[i]);
    end
  end

  assign w_leak   = (r_leak_sh == '0) ? '0 : (V >> r_leak_sh);
  assign w_nv     = c_nv_w'(V) - c_nv_w'(w_leak) + c_nv_w'(w_sum);
  assign w_nv_sat = (w_nv > c_nv_w'({W{1'b1}})) ? {W{1'b1}} : w_nv[W-1:0];
  assign w_fire   = (r_thresh != '0) && (w_nv_sat >= r_thresh);

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = V;
    w_axon_nxt  = 1'b0;
    w_rcnt_nxt  = r_rcnt;
    if (!w_frozen) begin
      case (r_state)
        ST_INTEG: begin
          if (w_fire) begin
            w_v_nxt    = '0;
            w_axon_nxt = 1'b1;
            if (r_refr != '0) begin
              w_state_nxt = ST_REFR;
              w_rcnt_nxt  = r_refr;
            end
          end else begin
            w_v_nxt = w_nv_sat;
          end
        end
        ST_REFR: begin
          w_v_nxt    = '0;
          w_rcnt_nxt = r_rcnt - REF_W'(1);
          if (r_rcnt <= REF_W'(1)) w_state_nxt = ST_INTEG;
        end
        default: w_state_nxt = ST_INTEG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INTEG;
      r_rcnt  <= '0;
      V       <= '0;
      axon    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      V       <= w_v_nxt;
      axon    <= w_axon_nxt;
    end
  end

  // Configuration capture and commit; only a frame of exactly the right length is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_w       <= '0;
      r_thresh  <= '1;
      r_leak_sh <= '0;
      r_refr    <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (set_vars) begin
        r_sreg <= {r_sreg[c_frame_len-2:0], cfg_bit};
        if (r_cnt != c_cnt_w'(c_frame_len + 1)) r_cnt <= r_cnt + c_cnt_w'(1);
      end else if (w_commit) begin
        r_cnt <= '0;
        if (r_cnt == c_cnt_w'(c_frame_len)) begin
          for (int i = 0; i < N; i++) begin
            r_w[i] <= r_sreg[c_w_lsb + i*WW +: WW];
          end
          r_thresh  <= r_sreg[c_thr_lsb +: W];
          r_leak_sh <= r_sreg[REF_W +: LEAK_W];
          r_refr    <= r_sreg[0 +: REF_W];
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_multi.sv
//==============================================================================
// Module      : tb_lif_neuron_multi
// Description : Directed self-checking bench for lif_neuron_multi.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lif_neuron_multi;

  localparam int L = 31;

  logic       clk;
  logic       rst;
  logic       set_vars;
  logic       cfg_bit;
  logic [3:0] syn;
  logic       axon;
  logic [7:0] V;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  lif_neuron_multi #(
    .W(8), .N(4), .WW(4), .LEAK_W(3), .REF_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_vars (set_vars),
    .cfg_bit  (cfg_bit),
    .syn      (syn),
    .axon     (axon),
    .V        (V),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] mkf(input logic [3:0] w3, input logic [3:0] w2,
                                       input logic [3:0] w1, input logic [3:0] w0,
                                       input logic [7:0] th, input logic [2:0] lk,
                                       input logic [3:0] rf);
    return {w3, w2, w1, w0, th, lk, rf};
  endfunction

  // Shifts the first nbits of f (MSB first), then drops set_vars for the commit edge
  task automatic send_frame(input logic [L-1:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      set_vars = 1'b1;
      cfg_bit  = f[L-1-i];
      step();
    end
    set_vars = 1'b0;
    cfg_bit  = 1'b0;
    step();
  endtask

  initial begin
    int exp_v[$];
    int exp_a[$];

    rst = 1'b0; set_vars = 1'b0; cfg_bit = 1'b0; syn = 4'b0000;
    #3;
    chk("rst_V", V, 0);
    chk("rst_axon", axon, 0);
    chk("rst_cfg_err", cfg_err, 0);
    step(); step();
    rst = 1'b1;
    syn = 4'b1111;
    step();
    chk("dflt_V", V, 0);

    // Basic fire: w0=4, thresh=20
    send_frame(mkf(0, 0, 0, 4, 20, 0, 0), L);
    chk("basic_cfg_err", cfg_err, 0);
    syn = 4'b0001;
    exp_v = '{4, 8, 12, 16, 0, 4};
    exp_a = '{0, 0, 0, 0, 1, 0};
    foreach (exp_v[k]) begin
      step();
      chk($sformatf("basic_V[%0d]", k), V, exp_v[k]);
      chk($sformatf("basic_axon[%0d]", k), axon, exp_a[k]);
    end

    // Short frame while syn=1111: V frozen, error pulse, old config kept
    syn = 4'b1111;
    send_frame('1, L - 1);
    chk("bad_cfg_err", cfg_err, 1);
    chk("freeze_V", V, 4);
    chk("freeze_axon", axon, 0);
    syn = 4'b0001;
    exp_v = '{8, 12, 16, 0};
    exp_a = '{0, 0, 0, 1};
    foreach (exp_v[k]) begin
      step();
      if (k == 0) chk("bad_cfg_err_pulse", cfg_err, 0);
      chk($sformatf("bad_V[%0d]", k), V, exp_v[k]);
      chk($sformatf("bad_axon[%0d]", k), axon, exp_a[k]);
    end

    // Leak: w0=8, thresh=255, leak_sh=2
    send_frame(mkf(0, 0, 0, 8, 255, 2, 0), L);
    chk("leak_cfg_err", cfg_err, 0);
    exp_v = '{8, 14, 19, 23, 26, 28, 29, 30, 31, 32, 32};
    foreach (exp_v[k]) begin
      step();
      chk($sformatf("leak_V[%0d]", k), V, exp_v[k]);
      chk($sformatf("leak_axon[%0d]", k), axon, 0);
    end

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    chk("arst_V", V, 0);
    chk("arst_axon", axon, 0);
    chk("arst_cfg_err", cfg_err, 0);
    step(); step();
    chk("arst_hold_V", V, 0);
    rst = 1'b1;
    step();
    chk("post_rst_V", V, 0);

    // Saturation: all weights 15, thresh=0 (never fire)
    send_frame(mkf(15, 15, 15, 15, 0, 0, 0), L);
    syn = 4'b1111;
    exp_v = '{60, 120, 180, 240, 255, 255};
    foreach (exp_v[k]) begin
      step();
      chk($sformatf("sat_V[%0d]", k), V, exp_v[k]);
      chk($sformatf("sat_axon[%0d]", k), axon, 0);
    end

    // Refractory: w0=10, thresh=20, refr=3
    rst = 1'b0;
    step();
    rst = 1'b1;
    send_frame(mkf(0, 0, 0, 10, 20, 0, 3), L);
    syn = 4'b0001;
    exp_v = '{10, 0, 0, 0, 0, 10, 0};
    exp_a = '{0, 1, 0, 0, 0, 0, 1};
    foreach (exp_v[k]) begin
      step();
      chk($sformatf("refr_V[%0d]", k), V, exp_v[k]);
      chk($sformatf("refr_axon[%0d]", k), axon, exp_a[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
